// File: rtl/sqrt_req_scheduler_if.sv
// rtl/sqrt_req_scheduler_if.sv - request/response and engine bundle for sqrt_req_scheduler
//
// Purpose: groups the client request/grant/response signals and the CORDIC
// engine Start/InpNum/Result/Stop signals into one interface.
// Ports (signals):
//   req, req_num              client request levels and packed 32-bit operands
//   gnt                       one-hot accept pulse back to the clients
//   resp_valid/id/result/err  tagged response
//   busy                      scheduler not idle
//   eng_start, eng_num        to engine Start/InpNum
//   eng_result, eng_stop      from engine Result/Stop
// Modports: slave = scheduler side, master = clients + engine side.
interface sqrt_req_scheduler_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_num;
  logic [N_REQ-1:0]    gnt;
  logic                resp_valid;
  logic [2:0]          resp_id;
  logic [23:0]         resp_result;
  logic                resp_err;
  logic                busy;
  logic                eng_start;
  logic [31:0]         eng_num;
  logic [23:0]         eng_result;
  logic                eng_stop;

  modport slave (
    input  req, req_num, eng_result, eng_stop,
    output gnt, resp_valid, resp_id, resp_result, resp_err, busy,
           eng_start, eng_num
  );

  modport master (
    output req, req_num, eng_result, eng_stop,
    input  gnt, resp_valid, resp_id, resp_result, resp_err, busy,
           eng_start, eng_num
  );
endinterface

// File: rtl/sqrt_req_scheduler.sv
// rtl/sqrt_req_scheduler.sv - round-robin scheduler sharing one sqrt CORDIC engine
//
// Purpose: arbitrates N_REQ requesters onto a single square-root engine,
// pulses the engine start, waits for its stop flag (with a watchdog) and
// returns the result tagged with the requester index.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sqrt_req_scheduler_if.slave (requests, grants, responses, engine)
// Parameters:
//   N_REQ    number of requesters (2..8)
//   TIMEOUT  maximum BUSY cycles before abort (>= 25)
module sqrt_req_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sqrt_req_scheduler_if.slave   bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       win_q;
  logic [CW-1:0]    cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic             eng_start_q;
  logic [31:0]      eng_num_q;
  logic             busy_q;
  logic             resp_valid_q;
  logic [2:0]       resp_id_q;
  logic [23:0]      resp_result_q;
  logic             resp_err_q;

  // Requests and operands padded to the 8-entry maximum so the winner index
  // can address them directly regardless of N_REQ.
  logic [7:0]       req_pad;
  logic [7:0][31:0] num_pad;
  logic [3:0]       idx_c;
  logic             found_d;
  logic [2:0]       win_d;
  logic [31:0]      num_d;
  logic [7:0]       win_oh_d;

  always_comb begin
    req_pad  = 8'(bus.req);
    num_pad  = 256'(bus.req_num);
    idx_c    = '0;
    found_d  = 1'b0;
    win_d    = '0;
    // Search starts at ptr_q and wraps, so the last winner goes to the back.
    for (int k = 0; k < N_REQ; k++) begin
      idx_c = {1'b0, ptr_q} + 4'(k);
      if (idx_c >= 4'(N_REQ)) begin
        idx_c = idx_c - 4'(N_REQ);
      end
      if (!found_d && req_pad[idx_c[2:0]]) begin
        found_d = 1'b1;
        win_d   = idx_c[2:0];
      end
    end
    num_d    = num_pad[win_d];
    win_oh_d = 8'd1 << win_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      eng_start_q   <= 1'b0;
      eng_num_q     <= '0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_result_q <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      gnt_q        <= '0;
      eng_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found_d) begin
            state_q     <= S_START;
            win_q       <= win_d;
            eng_num_q   <= num_d;
            gnt_q       <= win_oh_d[N_REQ-1:0];
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_START: begin
          ptr_q   <= (win_q == 3'(N_REQ-1)) ? 3'd0 : win_q + 3'd1;
          state_q <= S_ARM;
        end
        S_ARM: begin
          // Engine stop flag is stale until it has sampled start; skip it.
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.eng_stop) begin
            state_q       <= S_DONE;
            resp_valid_q  <= 1'b1;
            resp_id_q     <= win_q;
            resp_result_q <= bus.eng_result;
            resp_err_q    <= 1'b0;
          end else if (cnt_q == CW'(TIMEOUT-1)) begin
            state_q       <= S_DONE;
            resp_valid_q  <= 1'b1;
            resp_id_q     <= win_q;
            resp_result_q <= '0;
            resp_err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.eng_start   = eng_start_q;
  assign bus.eng_num     = eng_num_q;
  assign bus.busy        = busy_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_id     = resp_id_q;
  assign bus.resp_result = resp_result_q;
  assign bus.resp_err    = resp_err_q;
endmodule

// File: doc/sqrt_req_scheduler.md
# sqrt_req_scheduler

Round-robin scheduler that shares one square-root CORDIC engine among `N_REQ` requesters. It arbitrates requests, starts the engine with a one-cycle start pulse, tracks the engine's stop flag through its 24-iteration run, and returns the result tagged with the requester index. A watchdog guards against a stalled engine. It sits between the client blocks and the engine's `Start`/`InpNum`/`Result`/`Stop` ports.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 32: maximum cycles in BUSY before the run is aborted (must be at least 25).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N_REQ  per-requester request level; held until `gnt` bit seen.
- `req_num`  in  32*N_REQ  operands; slice i = bits [32i+31:32i]; stable while `req[i]`=1.
- `gnt`  out  N_REQ  one-hot, one-cycle pulse: operand of requester i accepted.
- `resp_valid`  out  1  one-cycle pulse: `resp_result`/`resp_id`/`resp_err` valid.
- `resp_id`  out  3  index of requester being answered.
- `resp_result`  out  24  square root, unsigned Q16.8 (floor(256*sqrt(operand))).
- `resp_err`  out  1  with `resp_valid`: watchdog abort, result forced to 0.
- `busy`  out  1  high in every state except IDLE.
- `eng_start`  out  1  to engine `Start`.
- `eng_num`  out  32  to engine `InpNum`; registered operand.
- `eng_result`  in  24  from engine `Result`.
- `eng_stop`  in  1  from engine `Stop`.

## Operation
- States: IDLE, START, ARM, BUSY, DONE.
- IDLE: if any `req` bit set, choose winner by round-robin from pointer `ptr`: the first set bit at index ptr, ptr+1, ..., wrapping mod N_REQ. Latch winner index and its operand into `eng_num`, then go to START. With no request, stay.
- START: `eng_start`=1 and `gnt[winner]`=1 for exactly this cycle. Set `ptr` = winner+1 mod N_REQ. Next state is ARM.
- ARM: one cycle. `eng_stop` is ignored here because the engine's flag is stale until it has sampled start. Next state is BUSY, and the watchdog counter clears to 0.
- BUSY: if `eng_stop`=1, go to DONE with err=0. If instead the counter reaches TIMEOUT-1, go to DONE with err=1. Otherwise increment the counter.
- DONE: `resp_valid`=1 and `resp_id`=winner.
  - err=0: `resp_result`=`eng_result`.
  - err=1: `resp_result`=0 and `resp_err`=1.
  - Next state is IDLE.
- `resp_result`, `resp_id` and `resp_err` are registered and hold their last value until the next DONE.
- A `req` bit deasserted before its grant is simply dropped. A request rising during a run waits; no queueing beyond the `req` level.
- `eng_num` holds the latched operand for the whole run.
- `req_num` changes after `gnt` do not affect the current run.
- Reset (asynchronous, any state):
  - State goes to IDLE, `ptr`=0, counter=0.
  - All outputs are 0, including `eng_start`, `eng_num`, `gnt`, `resp_*` and `busy`.
  - An engine run in flight is abandoned; the next START reinitialises the engine.

## Timing
- Request seen in IDLE at cycle t: `gnt`/`eng_start` at t+1.
- With the companion engine (`Stop` rises 24 rising edges after the edge that samples `Start`), `resp_valid` is 26 cycles after the `gnt` cycle.
- Back-to-back throughput: one result per 28 cycles (IDLE 1 + START 1 + ARM 1 + BUSY 24 + DONE 1).
- `gnt` and `resp_valid` never coincide; at most one `gnt` bit set per cycle.
- Watchdog abort: `resp_valid` with `resp_err`=1 comes TIMEOUT+1 cycles after ARM.

## Test plan
- Single request on index 0 with operand 16: `gnt`=0001 once, then `resp_valid` 26 cycles later with `resp_id`=0, `resp_result`=0x000400, `resp_err`=0.
- Requests on index 1 (operand 2) and index 3 (operand 0xFFFFFFFF) held together from reset:
  - Index 1 is served first with result 0x00016A.
  - Index 3 is served second with result 0xFFFFFF.
  - The grants are 28 cycles apart.
- All four requesters held continuously for 8 grants: grant order 0,1,2,3,0,1,2,3. Operand 0 yields 0x000000.
- Engine model with `eng_stop` stuck at 0 and TIMEOUT=32: `resp_valid` with `resp_err`=1 and `resp_result`=0. The next request then completes normally.
- `rst_n` pulsed low mid-BUSY:
  - All outputs are 0 immediately, with no `resp_valid` for the aborted run.
  - After release, a pending `req[2]` is granted first (`ptr`=0 search, index 2 is the first set bit).
- `req[1]` withdrawn one cycle after assertion while another run is active: no `gnt[1]` and no response for index 1.
